// File: rtl/anita4_trig_pkg.sv
// Shared constants and read-FSM encoding for the ANITA-4 trigger scaler.
package anita4_trig_pkg;

   localparam int DEF_NCH    = 16;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_PERIOD = 1000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ACK   = 2'd2
   } rd_state_t;

   // Bits needed to index n items; never less than one bit.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/anita4_scaler_chan.sv
// One scaler channel: rising-edge detect, saturating live counter and
// gate-result holding register.
module anita4_scaler_chan
   import anita4_trig_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_trig,
   input  logic             i_tc,
   input  logic             i_hold,
   output logic [WIDTH-1:0] o_hold_nxt
);

   logic             r_prev;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_hold;
   logic             w_edge;
   logic [WIDTH-1:0] w_cnt_inc;

   assign w_edge    = i_trig & ~r_prev;
   assign w_cnt_inc = (w_edge && (r_cnt != {WIDTH{1'b1}})) ? r_cnt + WIDTH'(1) : r_cnt;

   // Next holding value is exported so a read landing on the terminal cycle
   // sees the gate that is closing, including its last edge.
   assign o_hold_nxt = (i_tc && !i_hold) ? w_cnt_inc : r_hold;

   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) begin
         r_prev <= 1'b0;
         r_cnt  <= '0;
         r_hold <= '0;
      end else begin
         r_prev <= i_trig;
         r_hold <= o_hold_nxt;
         r_cnt  <= i_tc ? '0 : w_cnt_inc;
      end
   end

endmodule

// File: rtl/anita4_trig_scaler.sv
// ANITA-4 trigger rate scaler: per-channel edge counters over a fixed gate,
// latched results with a HOLD lock, and a three-state readout FSM.
module anita4_trig_scaler
   import anita4_trig_pkg::*;
#(
   parameter int NCH    = DEF_NCH,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int PERIOD = DEF_PERIOD
) (
   input  logic                     i_clk,
   input  logic                     i_clr,
   input  logic [NCH-1:0]           i_trig,
   input  logic                     i_hold,
   input  logic                     i_rd_req,
   input  logic [idx_bits(NCH)-1:0] i_rd_addr,
   output logic                     o_rd_ack,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_update,
   output logic                     o_overrun
);

   localparam int AW = idx_bits(NCH);
   localparam int TW = idx_bits(PERIOD);

   logic [TW-1:0]    r_timer;
   logic             w_tc;
   logic [WIDTH-1:0] w_hold_nxt [NCH];
   logic [WIDTH-1:0] w_rd_sel;
   rd_state_t        r_state;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] r_rd_data;
   logic             r_rd_ack;
   logic             r_update;
   logic             r_overrun;

   assign w_tc = (r_timer == TW'(PERIOD - 1));

   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) r_timer <= '0;
      else       r_timer <= w_tc ? '0 : r_timer + TW'(1);
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      anita4_scaler_chan #(.WIDTH(WIDTH)) u_chan (
         .i_clk      (i_clk),
         .i_clr      (i_clr),
         .i_trig     (i_trig[g]),
         .i_tc       (w_tc),
         .i_hold     (i_hold),
         .o_hold_nxt (w_hold_nxt[g])
      );
   end

   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) begin
         r_update  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_update <= w_tc & ~i_hold;
         if (w_tc && i_hold) r_overrun <= 1'b1;
      end
   end

   // Out-of-range addresses fall through to zero.
   always_comb begin
      w_rd_sel = '0;
      for (int i = 0; i < NCH; i++)
         if (r_addr == AW'(i)) w_rd_sel = w_hold_nxt[i];
   end

   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_rd_data <= '0;
         r_rd_ack  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rd_ack <= 1'b0;
               if (i_rd_req) begin
                  r_addr  <= i_rd_addr;
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               r_rd_data <= w_rd_sel;
               r_rd_ack  <= 1'b1;
               r_state   <= ST_ACK;
            end
            ST_ACK: begin
               r_rd_ack <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_rd_ack <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_rd_ack  = r_rd_ack;
   assign o_rd_data = r_rd_data;
   assign o_update  = r_update;
   assign o_overrun = r_overrun;

endmodule

// File: tb/tb_anita4_trig_scaler.sv
// Self-checking bench: a PERIOD=10 scaler for gate/readout behaviour and a
// WIDTH=4 scaler for saturation, with read results checked via a scoreboard.
module tb_anita4_trig_scaler;

   logic        clk = 1'b0;
   logic        clr;

   logic [11:0] trig_a;
   logic        hold_a, rdreq_a;
   logic [3:0]  rdaddr_a;
   logic        rdack_a, upd_a, ovr_a;
   logic [15:0] rddata_a;

   logic [3:0]  trig_b;
   logic        hold_b, rdreq_b;
   logic [1:0]  rdaddr_b;
   logic        rdack_b, upd_b, ovr_b;
   logic [3:0]  rddata_b;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          req_cyc = 0;
   logic [15:0] sb_q[$];

   anita4_trig_scaler #(.NCH(12), .WIDTH(16), .PERIOD(10)) dut_a (
      .i_clk(clk), .i_clr(clr), .i_trig(trig_a), .i_hold(hold_a),
      .i_rd_req(rdreq_a), .i_rd_addr(rdaddr_a), .o_rd_ack(rdack_a),
      .o_rd_data(rddata_a), .o_update(upd_a), .o_overrun(ovr_a)
   );

   anita4_trig_scaler #(.NCH(4), .WIDTH(4), .PERIOD(48)) dut_b (
      .i_clk(clk), .i_clr(clr), .i_trig(trig_b), .i_hold(hold_b),
      .i_rd_req(rdreq_b), .i_rd_addr(rdaddr_b), .o_rd_ack(rdack_b),
      .o_rd_data(rddata_b), .o_update(upd_b), .o_overrun(ovr_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) tick();
   endtask

   task automatic start_read_a(input logic [3:0] addr, input logic [15:0] exp_val);
      rdreq_a  = 1'b1;
      rdaddr_a = addr;
      sb_q.push_back(exp_val);
      req_cyc  = cyc;
      tick();
      rdreq_a  = 1'b0;
   endtask

   task automatic finish_read_a(input string name);
      int          n;
      logic [15:0] e;
      n = 0;
      while (rdack_a !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
      checks++;
      if (rdack_a !== 1'b1) begin
         errors++;
         $display("FAIL %s_ack: rd_ack=%b expected 1 within 6 cycles", name, rdack_a);
      end else begin
         checks++;
         if (cyc - req_cyc != 2) begin
            errors++;
            $display("FAIL %s_latency: ack after %0d cycles expected 2", name, cyc - req_cyc);
         end
         checks++;
         if (rddata_a !== e) begin
            errors++;
            $display("FAIL %s_data: rd_data=%0d expected %0d", name, rddata_a, e);
         end
      end
      tick();
      checks++;
      if (rdack_a !== 1'b0) begin
         errors++;
         $display("FAIL %s_ack_width: rd_ack=%b expected 0", name, rdack_a);
      end
   endtask

   task automatic read_a(input logic [3:0] addr, input logic [15:0] exp_val, input string name);
      start_read_a(addr, exp_val);
      finish_read_a(name);
   endtask

   task automatic read_b(input logic [1:0] addr, input logic [3:0] exp_val, input string name);
      logic [15:0] e;
      rdreq_b  = 1'b1;
      rdaddr_b = addr;
      sb_q.push_back({12'd0, exp_val});
      tick();
      rdreq_b  = 1'b0;
      tick();
      e = sb_q.pop_front();
      checks++;
      if (rdack_b !== 1'b1 || {12'd0, rddata_b} !== e) begin
         errors++;
         $display("FAIL %s: rd_ack=%b rd_data=%0d expected ack 1 data %0d", name, rdack_b, rddata_b, e);
      end
      tick();
   endtask

   task automatic test_reset();
      clr = 1'b1;
      trig_a = '0; trig_a[3] = 1'b1;
      hold_a = 1'b0; rdreq_a = 1'b0; rdaddr_a = '0;
      trig_b = '0; hold_b = 1'b0; rdreq_b = 1'b0; rdaddr_b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rdack_a, upd_a, ovr_a} !== 3'b000 || rddata_a !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: ack/upd/ovr=%b%b%b data=%0d expected 000 data 0",
                  rdack_a, upd_a, ovr_a, rddata_a);
      end
      clr = 1'b0;
      cyc = 0;
   endtask

   task automatic test_basic();
      for (int k = 0; k < 12; k++) begin
         trig_a[0] = (k == 1 || k == 3 || k == 5 || k == 11);
         trig_a[3] = (k < 3);
         checks++;
         if (upd_a !== (k == 10)) begin
            errors++;
            $display("FAIL basic_update_c%0d: update=%b expected %b", k, upd_a, (k == 10));
         end
         tick();
      end
      read_a(4'd0, 16'd3, "basic_ch0");
      read_a(4'd3, 16'd1, "reset_high_ch3");
      trig_a[0] = 1'b0;
   endtask

   task automatic test_held();
      wait_cyc(20);
      trig_a[5] = 1'b1;
      wait_cyc(30);
      read_a(4'd5, 16'd1, "held_gate0");
      wait_cyc(40);
      read_a(4'd5, 16'd0, "held_gate1");
      wait_cyc(50);
      read_a(4'd5, 16'd0, "held_gate2");
      wait_cyc(70);
      trig_a[5] = 1'b0;
   endtask

   task automatic test_terminal_edge();
      wait_cyc(75);
      trig_a[1] = 1'b1;
      tick();
      trig_a[1] = 1'b0;
      wait_cyc(78);
      start_read_a(4'd1, 16'd2);
      trig_a[1] = 1'b1;
      finish_read_a("term_edge_fetch");
      trig_a[1] = 1'b0;
      wait_cyc(83);
      trig_a[1] = 1'b1;
      tick();
      trig_a[1] = 1'b0;
      wait_cyc(90);
      read_a(4'd1, 16'd1, "term_next_gate");
   endtask

   task automatic test_hold();
      wait_cyc(101); trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
      wait_cyc(103); trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
      wait_cyc(105); trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
      wait_cyc(110);
      read_a(4'd1, 16'd3, "hold_before");
      trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
      wait_cyc(115);
      hold_a = 1'b1;
      trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
      read_a(4'd1, 16'd3, "hold_read_locked");
      tick();
      checks++;
      if (upd_a !== 1'b0 || ovr_a !== 1'b1) begin
         errors++;
         $display("FAIL hold_terminal: update=%b overrun=%b expected 0 1", upd_a, ovr_a);
      end
      hold_a = 1'b0;
      read_a(4'd1, 16'd3, "hold_unchanged");
      wait_cyc(124); trig_a[1] = 1'b1; tick(); trig_a[1] = 1'b0;
      wait_cyc(130);
      checks++;
      if (upd_a !== 1'b1 || ovr_a !== 1'b1) begin
         errors++;
         $display("FAIL hold_after: update=%b overrun=%b expected 1 1", upd_a, ovr_a);
      end
      read_a(4'd1, 16'd1, "hold_live_cleared");
   endtask

   task automatic test_read_corners();
      wait_cyc(134); trig_a[4] = 1'b1; tick(); trig_a[4] = 1'b0;
      wait_cyc(136); trig_a[4] = 1'b1; tick(); trig_a[4] = 1'b0;
      wait_cyc(140);
      read_a(4'd12, 16'd0, "addr_out_of_range");
      rdreq_a  = 1'b1;
      rdaddr_a = 4'd4;
      sb_q.push_back(16'd2);
      tick();
      rdaddr_a = 4'd12;
      tick();
      rdreq_a = 1'b0;
      checks++;
      if (rdack_a !== 1'b1 || rddata_a !== sb_q.pop_front()) begin
         errors++;
         $display("FAIL b2b_first: rd_ack=%b rd_data=%0d expected ack 1 data 2", rdack_a, rddata_a);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (rdack_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored_%0d: rd_ack=%b expected 0", k, rdack_a);
         end
      end
   endtask

   task automatic test_clr_mid_read();
      start_read_a(4'd4, 16'd2);
      clr = 1'b1;
      #1;
      void'(sb_q.pop_front());
      checks++;
      if (rddata_a !== 16'd0 || rdack_a !== 1'b0 || ovr_a !== 1'b0) begin
         errors++;
         $display("FAIL clr_async: data=%0d ack=%b overrun=%b expected 0 0 0", rddata_a, rdack_a, ovr_a);
      end
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      cyc = 0;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (rdack_a !== 1'b0 || upd_a !== (k == 10)) begin
            errors++;
            $display("FAIL clr_first_gate_c%0d: ack=%b update=%b expected 0 %b", k, rdack_a, upd_a, (k == 10));
         end
         tick();
      end
   endtask

   task automatic test_saturate();
      wait_cyc(48);
      checks++;
      if (upd_b !== 1'b1) begin
         errors++;
         $display("FAIL sat_gate_len: update_b=%b expected 1", upd_b);
      end
      for (int j = 0; j < 48; j++) begin
         trig_b[0] = (j % 2 == 0) && (j < 40);
         trig_b[1] = (j % 2 == 0) && (j < 30);
         trig_b[2] = (j % 2 == 0) && (j < 28);
         tick();
      end
      trig_b = '0;
      read_b(2'd0, 4'd15, "sat_20_edges");
      read_b(2'd1, 4'd15, "sat_15_edges");
      read_b(2'd2, 4'd14, "sat_14_edges");
      read_b(2'd3, 4'd0,  "sat_idle_ch");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_held();
      test_terminal_edge();
      test_hold();
      test_read_corners();
      test_clr_mid_read();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/anita4_trig_scaler.md
ANITA4_TRIG_SCALER -- requirements
Module: anita4_trig_scaler

Interface
REQ-001 Parameter NCH, default 16, number of single-pol trigger channels counted.
REQ-002 Parameter WIDTH, default 16, scaler count width in bits.
REQ-003 Parameter PERIOD, default 1000, gate length in CLK cycles, legal range 2..2^24.
REQ-004 CLK  input  1  sole clock, same domain as the upstream TRIG_SYNC outputs.
REQ-005 CLR  input  1  asynchronous, active-high reset.
REQ-006 TRIG  input  NCH  per-channel oneshot, bit 0 of each upstream TRIG_SYNC, synchronous to CLK.
REQ-007 HOLD  input  1  readout lock; defers transfer of new gate results.
REQ-008 RD_REQ  input  1  read request, single-cycle pulse.
REQ-009 RD_ADDR  input  log2(NCH)  channel index for the read.
REQ-010 RD_ACK  output  1  read-complete pulse.
REQ-011 RD_DATA  output  WIDTH  latched scaler value.
REQ-012 UPDATE  output  1  one-cycle pulse when a new gate result set is latched.
REQ-013 OVERRUN  output  1  sticky flag: a gate result was discarded while HOLD was high.

Function
REQ-014 Each channel shall count rising edges of TRIG (low in cycle n-1, high in cycle n); a level held high shall count once.
REQ-015 Live counters shall saturate at 2^WIDTH-1 and never wrap.
REQ-016 Gate timer shall count 0..PERIOD-1 and wrap; the terminal cycle is timer = PERIOD-1.
REQ-017 At terminal cycle with HOLD low, live counts, including any edge in that same cycle, shall copy to holding registers, live counters shall clear, and UPDATE shall pulse on the next cycle.
REQ-018 At terminal cycle with HOLD high, holding registers shall stay unchanged, live counters shall clear, that gate's result shall be discarded, and OVERRUN shall set.
REQ-019 OVERRUN shall clear only on CLR.
REQ-020 Read FSM states: IDLE, FETCH, ACK.
REQ-021 IDLE -> FETCH on RD_REQ; RD_ADDR shall be captured in that cycle.
REQ-022 FETCH -> ACK; RD_DATA shall be loaded from the holding register at the captured address.
REQ-023 ACK -> IDLE; RD_ACK shall be high for exactly this one cycle, i.e. 2 cycles after RD_REQ.
REQ-024 RD_REQ shall be ignored outside IDLE.
REQ-025 RD_DATA shall hold its value until the next FETCH.
REQ-026 RD_ADDR >= NCH shall return all-zeros and still produce RD_ACK.
REQ-027 A holding-register transfer in the FETCH cycle shall be visible to that read; holding registers shall be read, never live counters.
REQ-028 HOLD shall not affect live counting or the read FSM.

Reset
REQ-029 CLR shall asynchronously zero live counters, holding registers, the gate timer, the edge-detect history, RD_DATA, RD_ACK, UPDATE and OVERRUN, and force the FSM to IDLE.
REQ-030 The edge-detect history reset to 0 shall cause a TRIG already high at CLR release to count one edge.
REQ-031 CLR asserted mid-read shall abort the read with no RD_ACK.
REQ-032 After CLR release the first gate shall be a full PERIOD cycles.

Structure
REQ-033 Shared package anita4_trig_pkg shall hold the FSM state encoding (IDLE, FETCH, ACK) and the default NCH, WIDTH and PERIOD constants.
REQ-034 One sub-module, anita4_scaler_chan, shall implement the per-channel edge detect, saturating counter and holding register, generated NCH times.
REQ-035 All sequential elements shall clear asynchronously on CLR.

Verification
REQ-036 PERIOD=10, 3 pulses on ch0 in gate 0 -> UPDATE at cycle 10; read ch0 -> RD_DATA=3, RD_ACK 2 cycles after RD_REQ.
REQ-037 TRIG[5] held high for 50 cycles -> ch5 latched count = 1 in the first gate, 0 in the following gates.
REQ-038 WIDTH=4, 20 edges in one gate -> latched value 15, no wrap.
REQ-039 HOLD high across terminal cycle -> no UPDATE, holding value unchanged, OVERRUN=1 until CLR.
REQ-040 Edge on ch1 exactly at terminal cycle -> counted in the closing gate; next gate starts at 0.
REQ-041 RD_REQ repeated while in FETCH, RD_ADDR=NCH, and CLR mid-read -> second request ignored, data 0 with RD_ACK, no RD_ACK after CLR.
